mux4_sel_reg: RTL and testbench

//  Registered 4:1 word multiplexer. Selects one of four WIDTH-bit operands via 2-bit S.

---
 rtl/mux4_pkg.sv | 7 +
 rtl/mux4_core.sv | 31 +++
 rtl/mux4_sel_reg.sv | 51 +++++
 tb/tb_mux4_sel_reg.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mux4_pkg.sv
// Shared select codes for the registered 4:1 word multiplexer.
package mux4_pkg;
   localparam logic [1:0] SEL_A = 2'b00;
   localparam logic [1:0] SEL_B = 2'b01;
   localparam logic [1:0] SEL_C = 2'b10;
   localparam logic [1:0] SEL_D = 2'b11;
endpackage

// File: rtl/mux4_core.sv
// Combinational WIDTH-bit 4:1 case mux; zero latency, no flow control.
module mux4_core
   import mux4_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       s,
   output logic [WIDTH-1:0] sel
);

   always_comb begin
      sel = d;
      case (s)
         SEL_A:   sel = a;
         SEL_B:   sel = b;
         SEL_C:   sel = c;
         SEL_D:   sel = d;
`ifdef SYNTHESIS
         default: sel = d;
`else
         // an X/Z select is made visible in simulation rather than masked
         default: sel = {WIDTH{1'bx}};
`endif
      endcase
   end

endmodule

// File: rtl/mux4_sel_reg.sv
// ALU result-select stage: 4:1 mux into a 1-cycle output register, no backpressure.
// MUX4_COMB_OUT_EN adds a zero-latency combinational copy of the mux output on Yc.
module mux4_sel_reg
   import mux4_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             En,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   input  logic [1:0]       S,
   input  logic             Vld_in,
`ifdef MUX4_COMB_OUT_EN
   output logic [WIDTH-1:0] Yc,
`endif
   output logic [WIDTH-1:0] Y,
   output logic             Vld_out
);

   logic [WIDTH-1:0] sel;

   mux4_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a   (A),
      .b   (B),
      .c   (C),
      .d   (D),
      .s   (S),
      .sel (sel)
   );

`ifdef MUX4_COMB_OUT_EN
   assign Yc = sel;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Y       <= '0;
         Vld_out <= 1'b0;
      end else if (En) begin
         Y       <= sel;
         Vld_out <= Vld_in;
      end
   end

endmodule

// File: tb/tb_mux4_sel_reg.sv
// Directed bench for mux4_sel_reg with hand-computed expectations.
module tb_mux4_sel_reg;
   localparam int WIDTH = 4;

   logic             Clk;
   logic             Reset_n;
   logic             En;
   logic [WIDTH-1:0] A, B, C, D;
   logic [1:0]       S;
   logic             Vld_in;
   logic [WIDTH-1:0] Y;
   logic             Vld_out;
`ifdef MUX4_COMB_OUT_EN
   logic [WIDTH-1:0] Yc;
`endif

   int checks = 0;
   int errors = 0;

   mux4_sel_reg #(
      .WIDTH (WIDTH)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .En      (En),
      .A       (A),
      .B       (B),
      .C       (C),
      .D       (D),
      .S       (S),
      .Vld_in  (Vld_in),
`ifdef MUX4_COMB_OUT_EN
      .Yc      (Yc),
`endif
      .Y       (Y),
      .Vld_out (Vld_out)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset_n = 1'b1;
      En      = 1'b1;
      Vld_in  = 1'b1;
      A = 4'hF; B = 4'hF; C = 4'hF; D = 4'hF;
      S = 2'b11;

      // reset takes effect before any clock edge
      #1 Reset_n = 1'b0;
      #1;
      check("rst_y_async", 8'(Y), 8'h0);
      check("rst_vld_async", 8'(Vld_out), 8'h0);
      tick();
      tick();
      check("rst_y_held", 8'(Y), 8'h0);
      check("rst_vld_held", 8'(Vld_out), 8'h0);

      Reset_n = 1'b1;
      A = 4'h1; B = 4'h2; C = 4'h4; D = 4'h8;
      for (int i = 0; i < 4; i++) begin
         S = 2'(i);
         #3;
         if (i == 1) check("latency_y_old", 8'(Y), 8'h1);
         tick();
         check($sformatf("sel_y_s%0d", i), 8'(Y), 8'(1 << i));
         check($sformatf("sel_vld_s%0d", i), 8'(Vld_out), 8'h1);
      end

      // hold with En low
      S = 2'b10;
      tick();
      check("load_c", 8'(Y), 8'h4);
      En = 1'b0;
      S  = 2'b11;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("hold_y_%0d", i), 8'(Y), 8'h4);
      end
      En = 1'b1;
      tick();
      check("release_hold", 8'(Y), 8'h8);

      Vld_in = 1'b0;
      S = 2'b01;
      tick();
      check("novld_y", 8'(Y), 8'h2);
      check("novld_vld", 8'(Vld_out), 8'h0);

      // all-ones word passes through untouched
      Vld_in = 1'b1;
      A = 4'hF;
      S = 2'b00;
      tick();
      check("ones_y", 8'(Y), 8'hF);
      S = 2'b01;
      #3;
      check("midcycle_stable", 8'(Y), 8'hF);

      // mid-cycle reset pulse
      S = 2'b11;
      tick();
      check("pre_rst_y", 8'(Y), 8'h8);
      #2 Reset_n = 1'b0;
      #1;
      check("pulse_rst_y", 8'(Y), 8'h0);
      check("pulse_rst_vld", 8'(Vld_out), 8'h0);
      Reset_n = 1'b1;
      tick();
      check("resume_y", 8'(Y), 8'h8);
      check("resume_vld", 8'(Vld_out), 8'h1);

`ifdef MUX4_COMB_OUT_EN
      S = 2'b10;
      #1;
      check("yc_comb", 8'(Yc), 8'h4);
      check("yc_y_old", 8'(Y), 8'h8);
      tick();
      check("yc_then_y", 8'(Y), 8'h4);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
